// File: rtl/hit_memory_reader_pkg.sv
// Shared widths, memory field positions and reader state encoding.
// Matches the layout used by the SSID writer.
package hit_memory_reader_pkg;

  localparam int SSIDBITS         = 12;
  localparam int COLINDEXBITS_HNM = 5;
  localparam int NCOLS_HNM        = 2 ** COLINDEXBITS_HNM;
  localparam int ROWINDEXBITS_HNM = SSIDBITS - COLINDEXBITS_HNM;
  localparam int HITINFOBITS      = 8;
  localparam int MAXHITNBITS      = 4;
  localparam int ROWINDEXBITS_HLM = 8;
  localparam int NCOLS_HCM        = 12;
  localparam int NCOLS_HLM        = 64;
  localparam int MAXHITS          = NCOLS_HLM / HITINFOBITS;

  localparam logic [MAXHITNBITS-1:0] MAXHITS_C =
    MAXHITNBITS'(MAXHITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HNM_WAIT,
    S_HNM_CHECK,
    S_HCM_WAIT,
    S_HCM_CHECK,
    S_HLM_WAIT,
    S_HLM_LOAD,
    S_STREAM
  } state_e;

endpackage

// File: rtl/hit_memory_reader_if.sv
// Query, memory read ports and hit stream of the reader.
// master = reader side, slave = memories plus requester/consumer.
interface hit_memory_reader_if;
  import hit_memory_reader_pkg::*;

  logic                        requestValid;
  logic [SSIDBITS-1:0]         requestSSID;
  logic                        requestReady;
  logic [ROWINDEXBITS_HNM-1:0] hnmAddress;
  logic [NCOLS_HNM-1:0]        hnmData;
  logic [SSIDBITS-1:0]         hcmAddress;
  logic [NCOLS_HCM-1:0]        hcmData;
  logic [ROWINDEXBITS_HLM-1:0] hlmAddress;
  logic [NCOLS_HLM-1:0]        hlmData;
  logic                        hitValid;
  logic [HITINFOBITS-1:0]      hitInfo;
  logic                        hitLast;
  logic                        hitReady;
  logic                        emptyValid;
  logic                        overflow;

  modport master (
    input  requestValid, requestSSID,
    input  hnmData, hcmData, hlmData, hitReady,
    output requestReady,
    output hnmAddress, hcmAddress, hlmAddress,
    output hitValid, hitInfo, hitLast,
    output emptyValid, overflow
  );

  modport slave (
    output requestValid, requestSSID,
    output hnmData, hcmData, hlmData, hitReady,
    input  requestReady,
    input  hnmAddress, hcmAddress, hlmAddress,
    input  hitValid, hitInfo, hitLast,
    input  emptyValid, overflow
  );

endinterface

// File: rtl/hit_memory_reader_hit_unpacker.sv
// Holds one HLM row and emits its hits oldest first.
// The row is left-aligned on load so the oldest hit is always on top.
module hit_unpacker
  import hit_memory_reader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NCOLS_HLM-1:0]   row,
  input  logic [MAXHITNBITS-1:0] count,
  input  logic                   hit_ready,
  output logic                   hit_valid,
  output logic [HITINFOBITS-1:0] hit_info,
  output logic                   hit_last,
  output logic                   done
);

  logic [NCOLS_HLM-1:0]   row_q, row_d;
  logic [MAXHITNBITS-1:0] rem_q, rem_d;
  logic                   fire;

  assign hit_valid = (rem_q != '0);
  assign hit_last  = (rem_q == MAXHITNBITS'(1));
  assign hit_info  = row_q[NCOLS_HLM-1 -: HITINFOBITS];
  assign fire      = hit_valid && hit_ready;
  assign done      = fire && hit_last;

  always_comb begin
    row_d = row_q;
    rem_d = rem_q;
    if (load) begin
      row_d = row << ((MAXHITS - int'(count)) * HITINFOBITS);
      rem_d = count;
    end else if (fire) begin
      // shifting in zeros leaves the row cleared after the last hit
      row_d = row_q << HITINFOBITS;
      rem_d = rem_q - MAXHITNBITS'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= '0;
      rem_q <= '0;
    end else begin
      row_q <= row_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/hit_memory_reader.sv
// Walks HNM bitmap, HCM count and HLM row for one SSID query
// and streams the stored hits to the consumer.
module hit_memory_reader
  import hit_memory_reader_pkg::*;
(
  input logic clock,
  input logic reset,
  hit_memory_reader_if.master bus
);

  state_e                      state_q, state_d;
  logic [SSIDBITS-1:0]         ssid_q, ssid_d;
  logic [ROWINDEXBITS_HNM-1:0] hnm_addr_q, hnm_addr_d;
  logic [SSIDBITS-1:0]         hcm_addr_q, hcm_addr_d;
  logic [ROWINDEXBITS_HLM-1:0] hlm_addr_q, hlm_addr_d;
  logic [MAXHITNBITS-1:0]      count_q, count_d;
  logic                        empty_q, empty_d;
  logic                        overflow_q, overflow_d;
  logic                        load;
  logic                        done;
  logic [MAXHITNBITS-1:0]      hcm_count;

  assign hcm_count        = bus.hcmData[MAXHITNBITS-1:0];
  assign bus.requestReady = (state_q == S_IDLE);
  assign bus.hnmAddress   = hnm_addr_q;
  assign bus.hcmAddress   = hcm_addr_q;
  assign bus.hlmAddress   = hlm_addr_q;
  assign bus.emptyValid   = empty_q;
  assign bus.overflow     = overflow_q;

  always_comb begin
    state_d    = state_q;
    ssid_d     = ssid_q;
    hnm_addr_d = hnm_addr_q;
    hcm_addr_d = hcm_addr_q;
    hlm_addr_d = hlm_addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    empty_d    = 1'b0;
    load       = 1'b0;
    case (state_q)
      S_IDLE: if (bus.requestValid) begin
        ssid_d     = bus.requestSSID;
        hnm_addr_d = bus.requestSSID[SSIDBITS-1:COLINDEXBITS_HNM];
        overflow_d = 1'b0;
        state_d    = S_HNM_WAIT;
      end
      S_HNM_WAIT: state_d = S_HNM_CHECK;
      S_HNM_CHECK: begin
        if (!bus.hnmData[ssid_q[COLINDEXBITS_HNM-1:0]]) begin
          empty_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          hcm_addr_d = ssid_q;
          state_d    = S_HCM_WAIT;
        end
      end
      S_HCM_WAIT: state_d = S_HCM_CHECK;
      S_HCM_CHECK: begin
        hlm_addr_d = bus.hcmData[NCOLS_HCM-1 -: ROWINDEXBITS_HLM];
        count_d    = hcm_count;
        if (hcm_count == '0) begin
          empty_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          // the row only holds MAXHITS hits; the rest are lost
          if (hcm_count > MAXHITS_C) begin
            count_d    = MAXHITS_C;
            overflow_d = 1'b1;
          end
          state_d = S_HLM_WAIT;
        end
      end
      S_HLM_WAIT: state_d = S_HLM_LOAD;
      S_HLM_LOAD: begin
        load    = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ssid_q     <= '0;
      hnm_addr_q <= '0;
      hcm_addr_q <= '0;
      hlm_addr_q <= '0;
      count_q    <= '0;
      empty_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ssid_q     <= ssid_d;
      hnm_addr_q <= hnm_addr_d;
      hcm_addr_q <= hcm_addr_d;
      hlm_addr_q <= hlm_addr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  hit_unpacker u_unpacker (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .row       (bus.hlmData),
    .count     (count_q),
    .hit_ready (bus.hitReady),
    .hit_valid (bus.hitValid),
    .hit_info  (bus.hitInfo),
    .hit_last  (bus.hitLast),
    .done      (done)
  );

endmodule

// File: tb/tb_hit_memory_reader.sv
// Bench for hit_memory_reader: memory models plus a query-level
// reference model of the expected empty/hit stream per SSID.
module tb_hit_memory_reader;
  import hit_memory_reader_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  hit_memory_reader_if bus ();

  hit_memory_reader dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  logic [NCOLS_HNM-1:0] hnm_mem [2**ROWINDEXBITS_HNM];
  logic [NCOLS_HCM-1:0] hcm_mem [2**SSIDBITS];
  logic [NCOLS_HLM-1:0] hlm_mem [2**ROWINDEXBITS_HLM];

  always @(posedge clock) begin
    bus.hnmData <= hnm_mem[bus.hnmAddress];
    bus.hcmData <= hcm_mem[bus.hcmAddress];
    bus.hlmData <= hlm_mem[bus.hlmAddress];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 always ready, 1 pattern 0,1,0,0,1,1, 2 random, 3 stall then ready
  task automatic do_query(input logic [SSIDBITS-1:0] ssid, input int mode);
    logic       hbit;
    logic       ovf;
    logic       rdy;
    logic       on;
    int         n, nn, empty_c, done_c, idx, c;
    logic [7:0] hlm_a;
    logic [63:0] row;
    logic [7:0] exp_hits[$];
    bit         pat[6] = '{0, 1, 0, 0, 1, 1};
    hbit    = hnm_mem[ssid[11:5]][ssid[4:0]];
    n       = int'(hcm_mem[ssid][3:0]);
    hlm_a   = hcm_mem[ssid][11:4];
    row     = hlm_mem[hlm_a];
    empty_c = -1;
    nn      = 0;
    ovf     = 1'b0;
    if (!hbit) empty_c = 2;
    else if (n == 0) empty_c = 4;
    else begin
      nn  = (n > MAXHITS) ? MAXHITS : n;
      ovf = (n > MAXHITS);
      for (int k = 0; k < nn; k++)
        exp_hits.push_back(row[(nn-1-k)*8 +: 8]);
    end
    chk("req_ready_before", bus.requestReady, 1);
    bus.requestValid = 1'b1;
    bus.requestSSID  = ssid;
    @(negedge clock);
    bus.requestValid = 1'b0;
    bus.requestSSID  = 12'($urandom);
    c      = 0;
    idx    = 0;
    done_c = empty_c;
    forever begin
      if (c == 0) chk("hnm_addr", bus.hnmAddress, ssid[11:5]);
      if (c == 2 && hbit) chk("hcm_addr", bus.hcmAddress, ssid);
      if (c == 4 && hbit) chk("hlm_addr", bus.hlmAddress, hlm_a);
      on = (empty_c < 0) && (c >= 6) && (idx < nn);
      chk("empty_valid", bus.emptyValid, c == empty_c);
      chk("overflow", bus.overflow, (empty_c < 0 && c >= 4) ? ovf : 1'b0);
      chk("hit_valid", bus.hitValid, on);
      chk("req_ready", bus.requestReady, done_c >= 0 && c >= done_c);
      if (on) begin
        chk("hit_info", bus.hitInfo, exp_hits[idx]);
        chk("hit_last", bus.hitLast, idx == nn - 1);
      end
      if (done_c >= 0 && c >= done_c) break;
      if (c > 200) begin
        chk("timeout", 0, 1);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c >= 6) ? pat[(c - 6) % 6] : 1'b0;
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (c >= 26);
      endcase
      bus.hitReady = rdy;
      if (on && rdy) begin
        idx++;
        if (idx == nn) done_c = c + 1;
      end
      @(negedge clock);
      c++;
    end
    bus.hitReady = 1'b0;
  endtask

  initial begin
    logic [SSIDBITS-1:0] s;
    for (int i = 0; i < 2**ROWINDEXBITS_HNM; i++) hnm_mem[i] = '0;
    for (int i = 0; i < 2**SSIDBITS; i++) hcm_mem[i] = '0;
    for (int i = 0; i < 2**ROWINDEXBITS_HLM; i++) hlm_mem[i] = '0;
    bus.requestValid = 1'b0;
    bus.requestSSID  = '0;
    bus.hitReady     = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", bus.requestReady, 1);
    chk("rst_hit_valid", bus.hitValid, 0);
    chk("rst_hit_last", bus.hitLast, 0);
    chk("rst_empty", bus.emptyValid, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_hit_info", bus.hitInfo, 0);
    chk("rst_addrs", {bus.hnmAddress, bus.hcmAddress, bus.hlmAddress}, 0);
    reset = 1'b0;
    @(negedge clock);

    do_query(12'h0A3, 0);
    hnm_mem[5][3] = 1'b1;
    hcm_mem[12'h0A3] = {8'h10, 4'd0};
    do_query(12'h0A3, 0);
    hcm_mem[12'h0A3] = {8'h10, 4'd3};
    hlm_mem[8'h10] = 64'h0000_0000_0011_2233;
    do_query(12'h0A3, 0);
    do_query(12'h0A3, 1);
    do_query(12'h0A3, 3);
    hcm_mem[12'h0A3] = {8'h10, 4'd12};
    hlm_mem[8'h10] = 64'h8877_6655_4433_2211;
    do_query(12'h0A3, 0);
    hcm_mem[12'h0A3] = {8'h10, 4'd3};
    hlm_mem[8'h10] = 64'h0000_0000_0011_2233;
    do_query(12'h0A3, 2);

    // reset in the middle of a stream
    bus.requestValid = 1'b1;
    bus.requestSSID  = 12'h0A3;
    @(negedge clock);
    bus.requestValid = 1'b0;
    repeat (6) @(negedge clock);
    chk("mid_hit0", bus.hitInfo, 8'h11);
    bus.hitReady = 1'b1;
    @(negedge clock);
    bus.hitReady = 1'b0;
    chk("mid_hit1", bus.hitInfo, 8'h22);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", bus.hitValid, 0);
    chk("mid_rst_ready", bus.requestReady, 1);
    chk("mid_rst_info", bus.hitInfo, 0);
    chk("mid_rst_empty", bus.emptyValid, 0);
    reset = 1'b0;
    @(negedge clock);
    do_query(12'h0A3, 0);

    for (int q = 0; q < 40; q++) begin
      s = 12'($urandom);
      hnm_mem[s[11:5]][s[4:0]] = ($urandom_range(0, 4) != 0);
      hcm_mem[s] = {8'($urandom), 4'($urandom_range(0, 12))};
      hlm_mem[hcm_mem[s][11:4]] = {$urandom, $urandom};
      do_query(s, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hit_memory_reader.md
# hit_memory_reader

Retrieval engine for the hit-storage memories filled by the SSID writer. Accepts one SSID query at a time and walks the three block memories. First it checks the hits-new bitmap (HNM), then the hit-count word (HCM), then the hit-list row (HLM). It streams every stored hit-info word for that SSID to the downstream consumer, oldest first, with valid/ready backpressure. It owns one read-only port on each memory and sits between the storage block and the track-fitting/readout logic.

## Interface
- SSIDBITS, 12: SSID width.
- COLINDEXBITS_HNM, 5: low SSID bits selecting the HNM column; NCOLS_HNM = 2**COLINDEXBITS_HNM.
- ROWINDEXBITS_HNM, 7: HNM row address width (SSIDBITS − COLINDEXBITS_HNM).
- HITINFOBITS, 8: width of one hit-info word.
- MAXHITNBITS, 4: width of the HCM count field.
- ROWINDEXBITS_HLM, 8: HLM address width.
- NCOLS_HCM, 12: HCM word width. The HLM address is in [NCOLS_HCM−1 -: ROWINDEXBITS_HLM] and the count is in [MAXHITNBITS−1:0].
- NCOLS_HLM, 64: HLM row width. MAXHITS = NCOLS_HLM/HITINFOBITS = 8.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- requestValid  in  1  query present.
- requestSSID  in  SSIDBITS  SSID to retrieve.
- requestReady  out  1  high only in IDLE.
- hnmAddress  out  ROWINDEXBITS_HNM  HNM read address.
- hnmData  in  NCOLS_HNM  HNM read data.
- hcmAddress  out  SSIDBITS  HCM read address.
- hcmData  in  NCOLS_HCM  HCM read data.
- hlmAddress  out  ROWINDEXBITS_HLM  HLM read address.
- hlmData  in  NCOLS_HLM  HLM read data.
- hitValid  out  1  hitInfo valid.
- hitInfo  out  HITINFOBITS  one stored hit.
- hitLast  out  1  marks the final hit for the query.
- hitReady  in  1  downstream accepts the hit.
- emptyValid  out  1  one-cycle pulse: the SSID has no hits.
- overflow  out  1  sticky per query: stored count > MAXHITS, so the stream was truncated.

## Operation
- Memory read latency is fixed at 1: the address registered at edge N gives valid data after edge N+1.
- State machine:
  - IDLE: on requestValid, latch the SSID, drive hnmAddress = SSID[SSIDBITS−1:COLINDEXBITS_HNM], go to HNM_WAIT.
  - HNM_WAIT → HNM_CHECK.
  - HNM_CHECK: if hnmData[SSID[COLINDEXBITS_HNM−1:0]] is 0, pulse emptyValid and go to IDLE. Otherwise drive hcmAddress = SSID and go to HCM_WAIT.
  - HCM_WAIT → HCM_CHECK.
  - HCM_CHECK:
    - Latch count and HLM address.
    - If count is 0, pulse emptyValid and go to IDLE.
    - Saturate count to MAXHITS and set overflow if it was clipped.
    - Drive hlmAddress and go to HLM_WAIT.
  - HLM_WAIT → HLM_LOAD.
  - HLM_LOAD: load the hlmData row and the remaining-count register, go to STREAM.
  - STREAM: present hits; go to IDLE after the handshake on hitLast.
- Packing: newer hits sit in the lower bits. With count n, hit k (k = 0 is the oldest) is at bits [(n−1−k)*HITINFOBITS +: HITINFOBITS]. The first output is the oldest hit.
- Handshake:
  - hitValid/hitInfo/hitLast stay stable until hitReady is sampled high.
  - A transfer happens on any edge where hitValid && hitReady.
  - hitLast = (remaining == 1).
- No new request is accepted until the current query finishes. No queueing.
- The bitmap and count are trusted as-is. Consistency with an in-flight clearMemory is the caller's responsibility.

## Timing
- Reset values: state IDLE, requestReady 1, hitValid 0, hitLast 0, emptyValid 0, overflow 0, hitInfo 0, all addresses 0.
- Reset asserted mid-query: return to IDLE on the next edge, drop the partial stream, no emptyValid.
- Request accepted at edge E0:
  - Empty in HNM: emptyValid high during the cycle after E2.
  - Empty in HCM (count 0): emptyValid high during the cycle after E4.
  - Hits present: first hitValid in the cycle after E6.
- With hitReady held high: one hit per cycle, and requestReady returns high the cycle after the last transfer.
- hitReady low throughout: the state is held indefinitely with no loss.
- overflow clears when the next request is accepted.

## Structure
- The shared parameter header holds the widths and the field-position constants, identical to those the writer uses.
- The shared package holds the state encoding.
- One sub-module, hit_unpacker: row load, remaining counter, oldest-first select, valid/ready/last logic.

## Test plan
- Bitmap bit clear: SSID 0x0A3 with HNM row 5 bit 3 = 0 → emptyValid at the cycle after E2, no hitValid.
- Bitmap set, count 0: HCM[0x0A3] = {addr 0x10, n 0} → emptyValid after E4.
- Three hits, always ready:
  - Setup: HCM = {0x10, 3}, HLM[0x10] low 24 bits = 0x112233.
  - Expected: hits 0x11, 0x22, 0x33 on consecutive cycles from the cycle after E6, hitLast on 0x33.
- Backpressure: same setup, hitReady toggled 0,1,0,0,1,1 → each hit held stable until accepted, order preserved.
- Overflow: count 12 with MAXHITS = 8 → exactly 8 hits streamed, overflow = 1; next request clears it.
- Reset during STREAM after one hit: outputs go to reset values on the next edge, requestReady = 1, and a new query completes correctly.
